// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
// BOOTH_ACC_EN (optional running accumulator) is handled in the top module.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } booth_state_e;

    typedef enum logic [2:0] {
        DIG_ZERO,
        DIG_POS1,
        DIG_POS2,
        DIG_NEG1,
        DIG_NEG2
    } booth_digit_e;

    function automatic int booth_digits(input int n);
        return n / 2 + 1;
    endfunction

    function automatic bit booth_width_ok(input int n);
        return (n >= 4) && ((n % 2) == 0);
    endfunction

    // Window is {b[2i+1], b[2i], b[2i-1]}
    function automatic booth_digit_e booth_decode(input logic [2:0] win);
        booth_digit_e dig;
        case (win)
            3'b001, 3'b010: dig = DIG_POS1;
            3'b011:         dig = DIG_POS2;
            3'b100:         dig = DIG_NEG2;
            3'b101, 3'b110: dig = DIG_NEG1;
            default:        dig = DIG_ZERO;
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Combinational Booth digit stage: turns one 3-bit multiplier window and the
// (already shifted) multiplicand into a signed partial product of width W.
module booth_r4_digit
    import booth_pkg::*;
#(
    parameter int W = 36
) (
    input  logic [2:0]   window_i,
    input  logic [W-1:0] mcand_i,
    output logic [W-1:0] pp_o
);

    booth_digit_e digit;
    logic [W-1:0] mag;
    logic         neg;

    always_comb begin
        digit = booth_decode(window_i);
        mag   = '0;
        neg   = 1'b0;
        case (digit)
            DIG_POS1: mag = mcand_i;
            DIG_POS2: mag = mcand_i << 1;
            DIG_NEG1: begin
                mag = mcand_i;
                neg = 1'b1;
            end
            DIG_NEG2: begin
                mag = mcand_i << 1;
                neg = 1'b1;
            end
            default:  mag = '0;
        endcase
        pp_o = neg ? (~mag + 1'b1) : mag;
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
// Define BOOTH_ACC_EN to add a running accumulator (acc_clr_i / acc_o ports).
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int N     = 16,
    parameter int ACC_W = 2*N+8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N-1:0]     a_i,
    input  logic [N-1:0]     b_i,
    input  logic             is_signed_i,
`ifdef BOOTH_ACC_EN
    input  logic             acc_clr_i,
    output logic [ACC_W-1:0] acc_o,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [2*N-1:0]   prod_o,
    output logic             busy_o
);

    localparam int XW     = N + 2;
    localparam int PW     = 2*N + 4;
    localparam int DIGITS = booth_digits(N);
    localparam int CW     = $clog2(DIGITS + 1);

    if (!booth_width_ok(N)) begin : g_bad_width
        $error("booth_r4_seq_mult: N must be even and at least 4");
    end
    if (ACC_W < 2*N) begin : g_bad_acc_width
        $error("booth_r4_seq_mult: ACC_W must be at least 2*N");
    end

    booth_state_e   state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [XW-1:0]  mplr_q, mplr_d;
    logic           prev_q, prev_d;
    logic [PW-1:0]  mcand_q, mcand_d;
    logic [PW-1:0]  pp_q, pp_d;
    logic [2*N-1:0] prod_q, prod_d;

    logic           accept;
    logic           out_hs;
    logic [PW-1:0]  a_ext;
    logic [XW-1:0]  b_ext;
    logic [PW-1:0]  pp_term;
    logic [PW-1:0]  pp_sum;

    assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign out_hs      = (state_q == DONE) && out_ready_i;
    assign busy_o      = (state_q == BUSY);
    assign out_valid_o = (state_q == DONE);
    assign prod_o      = prod_q;

    assign a_ext = {{(PW-N){is_signed_i & a_i[N-1]}}, a_i};
    assign b_ext = {{2{is_signed_i & b_i[N-1]}}, b_i};

    // The multiplicand register is pre-shifted by 2i, so the digit stage is shift-free
    booth_r4_digit #(
        .W (PW)
    ) u_digit (
        .window_i ({mplr_q[1:0], prev_q}),
        .mcand_i  (mcand_q),
        .pp_o     (pp_term)
    );

    assign pp_sum = pp_q + pp_term;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mplr_d  = mplr_q;
        prev_d  = prev_q;
        mcand_d = mcand_q;
        pp_d    = pp_q;
        prod_d  = prod_q;

        case (state_q)
            IDLE: begin
                if (accept) state_d = BUSY;
            end
            BUSY: begin
                cnt_d   = cnt_q - 1'b1;
                pp_d    = pp_sum;
                mplr_d  = mplr_q >> 2;
                prev_d  = mplr_q[1];
                mcand_d = mcand_q << 2;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    prod_d  = pp_sum[2*N-1:0];
                end
            end
            DONE: begin
                if (out_hs) state_d = accept ? BUSY : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Acceptance only happens in IDLE or DONE, so it never collides with a BUSY step
        if (accept) begin
            mplr_d  = b_ext;
            prev_d  = 1'b0;
            mcand_d = a_ext;
            pp_d    = '0;
            cnt_d   = CW'(DIGITS);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mplr_q  <= '0;
            prev_q  <= 1'b0;
            mcand_q <= '0;
            pp_q    <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mplr_q  <= mplr_d;
            prev_q  <= prev_d;
            mcand_q <= mcand_d;
            pp_q    <= pp_d;
            prod_q  <= prod_d;
        end
    end

`ifdef BOOTH_ACC_EN
    logic             signed_q, signed_d;
    logic             clr_q, clr_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] prod_ext;

    assign prod_ext = {{(ACC_W-2*N){signed_q & prod_q[2*N-1]}}, prod_q};
    assign acc_o    = acc_q;

    // Mode flags belong to the result in DONE; a same-edge new accept overwrites them after use
    always_comb begin
        signed_d = signed_q;
        clr_d    = clr_q;
        acc_d    = acc_q;
        if (out_hs) acc_d = (clr_q ? '0 : acc_q) + prod_ext;
        if (accept) begin
            signed_d = is_signed_i;
            clr_d    = acc_clr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            signed_q <= 1'b0;
            clr_q    <= 1'b0;
            acc_q    <= '0;
        end else begin
            signed_q <= signed_d;
            clr_q    <= clr_d;
            acc_q    <= acc_d;
        end
    end
`endif

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed plus randomized bench for booth_r4_seq_mult (N=16).
// Define BOOTH_ACC_EN to also exercise the accumulator.
module tb_booth_r4_seq_mult;

    localparam int N     = 16;
    localparam int ACC_W = 2*N + 8;
    localparam int LAT   = N/2 + 1;

    logic             clk;
    logic             rstN;
    logic             inValid;
    logic             inReady;
    logic [N-1:0]     aIn;
    logic [N-1:0]     bIn;
    logic             isSigned;
    logic             accClr;
    logic             outValid;
    logic             outReady;
    logic [2*N-1:0]   prod;
    logic             busy;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] accRef;

    int passCount = 0;
    int checkCount = 0;

    booth_r4_seq_mult #(
        .N     (N),
        .ACC_W (ACC_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .a_i         (aIn),
        .b_i         (bIn),
        .is_signed_i (isSigned),
`ifdef BOOTH_ACC_EN
        .acc_clr_i   (accClr),
        .acc_o       (acc),
`endif
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .prod_o      (prod),
        .busy_o      (busy)
    );

`ifndef BOOTH_ACC_EN
    assign acc = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer product, truncated to 2N bits
    function automatic logic [2*N-1:0] refProduct(input logic [N-1:0] x, input logic [N-1:0] y,
                                                  input logic sgn);
        longint px, py;
        px = sgn ? longint'($signed(x)) : longint'(x);
        py = sgn ? longint'($signed(y)) : longint'(y);
        return (2*N)'(px * py);
    endfunction

    function automatic logic [ACC_W-1:0] refAcc(input logic [ACC_W-1:0] cur, input logic clr,
                                                input logic [2*N-1:0] p, input logic sgn);
        longint base, add;
        base = clr ? 64'sd0 : longint'(cur);
        add  = sgn ? longint'($signed(p)) : longint'(p);
        return ACC_W'(base + add);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Full transaction: accept, scramble inputs in flight, wait for result, consume it
    task automatic applyStimulus(input logic [N-1:0] x, input logic [N-1:0] y, input logic sgn,
                                 input logic clr, input string tag);
        int cyc;
        logic [2*N-1:0] expProd;
        expProd = refProduct(x, y, sgn);
        @(negedge clk);
        cyc = 0;
        while (!inReady && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, "_inready"}, 64'(inReady), 64'd1);
        aIn = x; bIn = y; isSigned = sgn; accClr = clr; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0; isSigned = ~sgn; accClr = ~clr;
        aIn = N'($urandom); bIn = N'($urandom);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
        cyc = 0;
        while (!outValid && cyc < 3*LAT) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput({tag, "_latency"}, 64'(cyc), 64'(LAT));
        checkOutput({tag, "_prod"}, 64'(prod), 64'(expProd));
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput({tag, "_drained"}, 64'(outValid), 64'd0);
`ifdef BOOTH_ACC_EN
        accRef = refAcc(accRef, clr, expProd, sgn);
        checkOutput({tag, "_acc"}, 64'(acc), 64'(accRef));
`endif
    endtask

    initial begin
        int cyc;
        int seen;
        logic [2*N-1:0] expA, expB;

        rstN = 1'b0; inValid = 1'b0; outReady = 1'b0;
        aIn = '0; bIn = '0; isSigned = 1'b0; accClr = 1'b0;
        accRef = '0;
        #12;
        checkOutput("rst_in_ready", 64'(inReady), 64'd1);
        checkOutput("rst_out_valid", 64'(outValid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_prod", 64'(prod), 64'd0);
`ifdef BOOTH_ACC_EN
        checkOutput("rst_acc", 64'(acc), 64'd0);
`endif
        @(negedge clk);
        rstN = 1'b1;

        applyStimulus(-16'sd6, 16'sd4, 1'b1, 1'b1, "s_m6x4");
        checkOutput("s_m6x4_const", 64'(prod), 64'hFFFF_FFE8);
        applyStimulus(16'sd7, -16'sd2, 1'b1, 1'b0, "s_7xm2");
        checkOutput("s_7xm2_const", 64'(prod), 64'hFFFF_FFF2);
        applyStimulus(16'h8000, 16'h8000, 1'b1, 1'b0, "s_min_sq");
        checkOutput("s_min_sq_const", 64'(prod), 64'h4000_0000);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "u_max_sq");
        checkOutput("u_max_sq_const", 64'(prod), 64'hFFFE_0001);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "s_m1_sq");
        checkOutput("s_m1_sq_const", 64'(prod), 64'h0000_0001);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        // Backpressure, then a simultaneous output/input handshake
        expA = refProduct(16'd1234, -16'sd3, 1'b1);
        expB = refProduct(-16'sd100, 16'sd50, 1'b1);
        @(negedge clk);
        aIn = 16'd1234; bIn = -16'sd3; isSigned = 1'b1; accClr = 1'b1; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        cyc = 0;
        while (!outValid && cyc < 3*LAT) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("bp_latency", 64'(cyc), 64'(LAT));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("bp_hold_valid%0d", i), 64'(outValid), 64'd1);
            checkOutput($sformatf("bp_hold_prod%0d", i), 64'(prod), 64'(expA));
            checkOutput($sformatf("bp_hold_inready%0d", i), 64'(inReady), 64'd0);
        end
        aIn = -16'sd100; bIn = 16'sd50; isSigned = 1'b1; accClr = 1'b0;
        inValid = 1'b1; outReady = 1'b1;
        #1;
        checkOutput("bp_inready_open", 64'(inReady), 64'd1);
        @(posedge clk); #1;
        inValid = 1'b0; outReady = 1'b0;
        checkOutput("b2b_busy", 64'(busy), 64'd1);
        checkOutput("b2b_out_valid", 64'(outValid), 64'd0);
`ifdef BOOTH_ACC_EN
        accRef = refAcc(accRef, 1'b1, expA, 1'b1);
        checkOutput("bp_acc", 64'(acc), 64'(accRef));
`endif
        cyc = 0;
        while (!outValid && cyc < 3*LAT) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("b2b_latency", 64'(cyc), 64'(LAT));
        checkOutput("b2b_prod", 64'(prod), 64'(expB));
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
`ifdef BOOTH_ACC_EN
        accRef = refAcc(accRef, 1'b0, expB, 1'b1);
        checkOutput("b2b_acc", 64'(acc), 64'(accRef));
`endif

        // Asynchronous reset in the fourth BUSY cycle drops the transaction
        @(negedge clk);
        aIn = 16'd300; bIn = 16'd300; isSigned = 1'b0; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("arst_out_valid", 64'(outValid), 64'd0);
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_in_ready", 64'(inReady), 64'd1);
        checkOutput("arst_prod", 64'(prod), 64'd0);
        accRef = '0;
`ifdef BOOTH_ACC_EN
        checkOutput("arst_acc", 64'(acc), 64'd0);
`endif
        @(negedge clk);
        rstN = 1'b1;
        seen = 0;
        for (int i = 0; i < 3*LAT; i++) begin
            @(negedge clk);
            if (outValid) seen++;
        end
        checkOutput("arst_no_stale_valid", 64'(seen), 64'd0);

        applyStimulus(16'sd127, 16'sd127, 1'b1, 1'b1, "acc_a");
`ifdef BOOTH_ACC_EN
        checkOutput("acc_a_const", 64'(acc), 64'd16129);
`endif
        applyStimulus(-16'sd126, -16'sd1, 1'b1, 1'b0, "acc_b");
`ifdef BOOTH_ACC_EN
        checkOutput("acc_b_const", 64'(acc), 64'd16255);
`endif
        applyStimulus(-16'sd5, -16'sd3, 1'b1, 1'b0, "acc_c");
`ifdef BOOTH_ACC_EN
        checkOutput("acc_c_const", 64'(acc), 64'd16270);
`endif
        applyStimulus(16'sd2, 16'sd3, 1'b1, 1'b1, "acc_d");
`ifdef BOOTH_ACC_EN
        checkOutput("acc_d_const", 64'(acc), 64'd6);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
